halfword_serializer: RTL and testbench

HALFWORD_SERIALIZER -- requirements
Module: halfword_serializer

---
 rtl/halfword_serializer_pkg.sv | 22 ++
 rtl/halfword_serializer_if.sv | 27 ++
 rtl/halfword_serializer.sv | 125 ++++++++++++
 tb/tb_halfword_serializer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/halfword_serializer_pkg.sv
// Purpose : shared constants and types for the halfword serializer slice.
// Contents: FSM state encodings, halfword/word widths, word/halfword types,
//           and the "fits in one beat" helper used by the serializer.
package halfword_serializer_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;  // no word held
  localparam logic [1:0] ST_SEND_LO = 2'd1;  // low half presented
  localparam logic [1:0] ST_SEND_HI = 2'd2;  // high half presented

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [HALF_W-1:0] half_t;

  // A word whose upper half is zero can be sent as a single beat.
  function automatic logic upper_is_zero(input word_t w);
    return (w[WORD_W-1:HALF_W] == '0);
  endfunction

endpackage

// File: rtl/halfword_serializer_if.sv
// Purpose : word-in / halfword-out valid-ready bundle for the serializer.
// Ports   : in_valid/in_ready/in_data (32-bit word stream),
//           out_valid/out_ready/out_data/out_hi/out_last (16-bit beat stream).
// Modports: slave = serializer view, master = producer/consumer (environment) view.
interface halfword_serializer_if;
  import halfword_serializer_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_data;
  logic  out_valid;
  logic  out_ready;
  half_t out_data;
  logic  out_hi;
  logic  out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_hi, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_hi, out_last
  );

endinterface

// File: rtl/halfword_serializer.sv
// Purpose     : splits 32-bit words into 16-bit beats, low half first; optionally one beat for zero-upper words.
// Latency     : first beat valid 1 cycle after input transfer; 1 word per 1 or 2 cycles sustained.
// Backpressure: out_ready=0 freezes the presented beat; in_ready only opens on a last-beat transfer or in IDLE.
// Ports       : clk, rst_n (async active-low); bus (slave modport) carries both streams;
//               zcount = saturating count of words sent as a single beat.
module halfword_serializer
  import halfword_serializer_pkg::*;
#(
  parameter bit COMPRESS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  halfword_serializer_if.slave  bus,
  output logic [HALF_W-1:0]     zcount
);

  logic [1:0]        state_q, state_d;
  word_t             word_q,  word_d;
  logic [HALF_W-1:0] zcount_q, zcount_d;

  logic  out_valid_c;
  logic  out_last_c;
  logic  out_hi_c;
  half_t out_data_c;
  logic  in_ready_c;
  logic  in_fire;
  logic  out_fire;

  // Outputs are a function of registered state only, so in_data never
  // reaches out_data combinationally and a stalled beat stays stable.
  always_comb begin
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    out_hi_c    = 1'b0;
    out_data_c  = '0;
    case (state_q)
      ST_SEND_LO: begin
        out_valid_c = 1'b1;
        out_data_c  = word_q[HALF_W-1:0];
        out_last_c  = COMPRESS && upper_is_zero(word_q);
      end
      ST_SEND_HI: begin
        out_valid_c = 1'b1;
        out_data_c  = word_q[WORD_W-1:HALF_W];
        out_hi_c    = 1'b1;
        out_last_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Accept a new word when empty, or on the very edge the last beat leaves
  // so consecutive words stream without a bubble. Never looks at in_valid.
  always_comb begin
    in_ready_c = (state_q == ST_IDLE) || (out_last_c && bus.out_ready);
  end

  always_comb begin
    in_fire  = bus.in_valid && in_ready_c;
    out_fire = out_valid_c && bus.out_ready;

    state_d  = state_q;
    word_d   = word_q;
    zcount_d = zcount_q;

    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          word_d  = bus.in_data;
          state_d = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        if (out_fire) begin
          if (!out_last_c) begin
            state_d = ST_SEND_HI;
          end else begin
            if (zcount_q != '1) begin
              zcount_d = zcount_q + 16'd1;
            end
            if (in_fire) begin
              word_d  = bus.in_data;
              state_d = ST_SEND_LO;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_SEND_HI: begin
        if (out_fire) begin
          if (in_fire) begin
            word_d  = bus.in_data;
            state_d = ST_SEND_LO;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      zcount_q <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      zcount_q <= zcount_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.out_hi    = out_hi_c;
  assign bus.out_last  = out_last_c;
  assign zcount        = zcount_q;

endmodule

// File: tb/tb_halfword_serializer.sv
// Bench for halfword_serializer: a COMPRESS=1 instance checked cycle by cycle
// against a beat-queue model, plus a COMPRESS=0 instance for the split-always case.
module tb_halfword_serializer;
  import halfword_serializer_pkg::*;

  typedef struct packed {
    logic [15:0] dat;
    logic        hi;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] zcount0, zcount1;

  halfword_serializer_if ifc0();
  halfword_serializer_if ifc1();

  halfword_serializer #(.COMPRESS(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(ifc0), .zcount(zcount0)
  );
  halfword_serializer #(.COMPRESS(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(ifc1), .zcount(zcount1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: beats still owed to the consumer, in order.
  beat_t q[$];
  int    zexp = 0;

  logic  obs_vld, obs_rdy, exp_vld, exp_rdy;
  beat_t obs_beat, exp_beat;
  logic  last_in_fire, last_out_fire;

  // One clock of stimulus on instance 0; starts and ends at a falling edge.
  // Captures observed/expected values for the caller to compare.
  task automatic tick(input logic iv, input logic [31:0] id, input logic ordy);
    ifc0.in_valid  = iv;
    ifc0.in_data   = id;
    ifc0.out_ready = ordy;
    #1;
    obs_vld  = ifc0.out_valid;
    obs_rdy  = ifc0.in_ready;
    obs_beat = '{dat: ifc0.out_data, hi: ifc0.out_hi, last: ifc0.out_last};
    exp_vld  = (q.size() > 0);
    exp_rdy  = (q.size() == 0) || (q.size() == 1 && ordy);
    exp_beat = exp_vld ? q[0] : '0;
    last_out_fire = exp_vld && ordy;
    last_in_fire  = iv && exp_rdy;
    @(posedge clk);
    if (last_out_fire) begin
      if (q[0].last && !q[0].hi && zexp < 65535) zexp++;
      void'(q.pop_front());
    end
    if (last_in_fire) begin
      if (id[31:16] == 16'h0) begin
        q.push_back('{dat: id[15:0], hi: 1'b0, last: 1'b1});
      end else begin
        q.push_back('{dat: id[15:0], hi: 1'b0, last: 1'b0});
        q.push_back('{dat: id[31:16], hi: 1'b1, last: 1'b1});
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 8 && q.size() > 0; i++) begin
      tick(1'b0, 32'h0, 1'b1);
      total++;
      if (obs_vld !== exp_vld || obs_rdy !== exp_rdy || (exp_vld && obs_beat !== exp_beat)) begin
        bad++;
        $display("FAIL %s_drain: got vld=%b rdy=%b beat=%h, want vld=%b rdy=%b beat=%h",
                 name, obs_vld, obs_rdy, obs_beat, exp_vld, exp_rdy, exp_beat);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc0.in_valid = 1'b0; ifc0.in_data = '0; ifc0.out_ready = 1'b1;
    ifc1.in_valid = 1'b0; ifc1.in_data = '0; ifc1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({ifc0.out_valid, ifc0.out_data, ifc0.out_hi, ifc0.out_last} !== 19'h0 || zcount0 !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: got vld=%b dat=%h hi=%b last=%b z=%h, want all zero",
               ifc0.out_valid, ifc0.out_data, ifc0.out_hi, ifc0.out_last, zcount0);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (ifc0.in_ready !== 1'b1 || ifc1.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b/%b, want 1/1", ifc0.in_ready, ifc1.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    tick(1'b1, 32'h0000_1234, 1'b1);
    tick(1'b0, 32'h0, 1'b1);
    total++;
    if (obs_vld !== 1'b1 || obs_beat !== beat_t'({16'h1234, 1'b0, 1'b1})) begin
      bad++;
      $display("FAIL single_beat: got vld=%b beat=%h, want vld=1 beat=%h",
               obs_vld, obs_beat, beat_t'({16'h1234, 1'b0, 1'b1}));
    end
    tick(1'b0, 32'h0, 1'b1);
    total++;
    if (obs_vld !== 1'b0 || zcount0 !== 16'd1) begin
      bad++;
      $display("FAIL single_zcount: got vld=%b z=%0d, want vld=0 z=1", obs_vld, zcount0);
    end
  endtask

  task automatic test_two_beat();
    tick(1'b1, 32'hABCD_5678, 1'b1);
    tick(1'b0, 32'h0, 1'b1);
    total++;
    if (obs_vld !== 1'b1 || obs_beat !== beat_t'({16'h5678, 1'b0, 1'b0})) begin
      bad++;
      $display("FAIL two_beat_lo: got vld=%b beat=%h, want 5678/hi0/last0", obs_vld, obs_beat);
    end
    tick(1'b0, 32'h0, 1'b1);
    total++;
    if (obs_vld !== 1'b1 || obs_beat !== beat_t'({16'hABCD, 1'b1, 1'b1})) begin
      bad++;
      $display("FAIL two_beat_hi: got vld=%b beat=%h, want ABCD/hi1/last1", obs_vld, obs_beat);
    end
    drain("two_beat");
    total++;
    if (zcount0 !== 16'd1) begin
      bad++;
      $display("FAIL two_beat_zcount: got %0d, want 1", zcount0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    logic [15:0] want  [4];
    logic [15:0] seen  [$];
    int idx = 0;
    int gaps = 0;
    words[0] = 32'h0000_0001; words[1] = 32'hFFFF_0002; words[2] = 32'h0000_0003;
    want[0] = 16'h0001; want[1] = 16'h0002; want[2] = 16'hFFFF; want[3] = 16'h0003;
    for (int c = 0; c < 12 && seen.size() < 4; c++) begin
      tick(idx < 3, (idx < 3) ? words[idx] : 32'h0, 1'b1);
      if (last_in_fire) idx++;
      if (obs_vld) seen.push_back(obs_beat.dat);
      else if (seen.size() > 0) gaps++;
      total++;
      if (obs_vld !== exp_vld || obs_rdy !== exp_rdy || (exp_vld && obs_beat !== exp_beat)) begin
        bad++;
        $display("FAIL stream_cycle%0d: got vld=%b rdy=%b beat=%h, want vld=%b rdy=%b beat=%h",
                 c, obs_vld, obs_rdy, obs_beat, exp_vld, exp_rdy, exp_beat);
      end
    end
    total++;
    if (seen.size() != 4 || gaps != 0) begin
      bad++;
      $display("FAIL stream_shape: got %0d beats with %0d gaps, want 4 beats 0 gaps", seen.size(), gaps);
    end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      total++;
      if (seen[i] !== want[i]) begin
        bad++;
        $display("FAIL stream_beat%0d: got %h, want %h", i, seen[i], want[i]);
      end
    end
    drain("stream");
    total++;
    if (zcount0 !== 16'd3) begin
      bad++;
      $display("FAIL stream_zcount: got %0d, want 3", zcount0);
    end
  endtask

  task automatic test_backpressure();
    tick(1'b1, 32'hABCD_5678, 1'b1);
    tick(1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, 32'h0000_0055, 1'b0);
      total++;
      if (obs_rdy !== 1'b0 || obs_vld !== 1'b1 || obs_beat !== beat_t'({16'hABCD, 1'b1, 1'b1})) begin
        bad++;
        $display("FAIL stall_cycle%0d: got rdy=%b vld=%b beat=%h, want rdy=0 vld=1 beat=ABCD/1/1",
                 c, obs_rdy, obs_vld, obs_beat);
      end
    end
    tick(1'b1, 32'h0000_0055, 1'b1);
    total++;
    if (obs_rdy !== 1'b1 || obs_beat !== beat_t'({16'hABCD, 1'b1, 1'b1})) begin
      bad++;
      $display("FAIL stall_release: got rdy=%b beat=%h, want rdy=1 beat=ABCD/1/1", obs_rdy, obs_beat);
    end
    tick(1'b0, 32'h0, 1'b1);
    total++;
    if (obs_vld !== 1'b1 || obs_beat !== beat_t'({16'h0055, 1'b0, 1'b1})) begin
      bad++;
      $display("FAIL stall_next_word: got vld=%b beat=%h, want 0055/0/1", obs_vld, obs_beat);
    end
    drain("stall");
    total++;
    if (zcount0 !== zexp[15:0]) begin
      bad++;
      $display("FAIL stall_zcount: got %0d, want %0d", zcount0, zexp);
    end
  endtask

  task automatic test_reset_mid_word();
    logic dead_seen = 1'b0;
    tick(1'b1, 32'hDEAD_BEEF, 1'b0);
    ifc0.in_valid = 1'b0;
    ifc0.out_ready = 1'b0;
    #1;
    total++;
    if (ifc0.out_valid !== 1'b1 || ifc0.out_data !== 16'hBEEF) begin
      bad++;
      $display("FAIL mid_reset_pre: got vld=%b dat=%h, want vld=1 dat=BEEF", ifc0.out_valid, ifc0.out_data);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ifc0.out_valid !== 1'b0 || ifc0.out_data !== 16'h0 || zcount0 !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset_async: got vld=%b dat=%h z=%h, want 0/0000/0000",
               ifc0.out_valid, ifc0.out_data, zcount0);
    end
    q.delete();
    zexp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(c == 0, 32'h1111_2222, 1'b1);
      if (obs_vld && obs_beat.dat === 16'hDEAD) dead_seen = 1'b1;
      total++;
      if (obs_vld !== exp_vld || obs_rdy !== exp_rdy || (exp_vld && obs_beat !== exp_beat)) begin
        bad++;
        $display("FAIL mid_reset_after%0d: got vld=%b rdy=%b beat=%h, want vld=%b rdy=%b beat=%h",
                 c, obs_vld, obs_rdy, obs_beat, exp_vld, exp_rdy, exp_beat);
      end
    end
    total++;
    if (dead_seen !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_dead_beat: got dead_seen=%b, want 0", dead_seen);
    end
  endtask

  task automatic test_random();
    logic        iv, ordy;
    logic [31:0] id;
    for (int c = 0; c < 400; c++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      id   = ($urandom_range(0, 1) != 0) ? {16'h0, 16'($urandom)} : $urandom;
      tick(iv, id, ordy);
      total++;
      if (obs_vld !== exp_vld || obs_rdy !== exp_rdy || (exp_vld && obs_beat !== exp_beat)) begin
        bad++;
        $display("FAIL random_cycle%0d: got vld=%b rdy=%b beat=%h, want vld=%b rdy=%b beat=%h",
                 c, obs_vld, obs_rdy, obs_beat, exp_vld, exp_rdy, exp_beat);
      end
    end
    drain("random");
    total++;
    if (zcount0 !== zexp[15:0]) begin
      bad++;
      $display("FAIL random_zcount: got %0d, want %0d", zcount0, zexp);
    end
  endtask

  task automatic test_no_compress();
    beat_t b;
    ifc1.in_valid = 1'b1; ifc1.in_data = 32'h0000_0007; ifc1.out_ready = 1'b1;
    #1;
    total++;
    if (ifc1.in_ready !== 1'b1 || ifc1.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL nocomp_idle: got rdy=%b vld=%b, want 1/0", ifc1.in_ready, ifc1.out_valid);
    end
    @(negedge clk);
    ifc1.in_valid = 1'b0;
    #1;
    b = '{dat: ifc1.out_data, hi: ifc1.out_hi, last: ifc1.out_last};
    total++;
    if (ifc1.out_valid !== 1'b1 || b !== beat_t'({16'h0007, 1'b0, 1'b0})) begin
      bad++;
      $display("FAIL nocomp_lo: got vld=%b beat=%h, want 0007/0/0", ifc1.out_valid, b);
    end
    @(negedge clk);
    #1;
    b = '{dat: ifc1.out_data, hi: ifc1.out_hi, last: ifc1.out_last};
    total++;
    if (ifc1.out_valid !== 1'b1 || b !== beat_t'({16'h0000, 1'b1, 1'b1})) begin
      bad++;
      $display("FAIL nocomp_hi: got vld=%b beat=%h, want 0000/1/1", ifc1.out_valid, b);
    end
    @(negedge clk);
    #1;
    total++;
    if (ifc1.out_valid !== 1'b0 || zcount1 !== 16'h0) begin
      bad++;
      $display("FAIL nocomp_end: got vld=%b z=%0d, want vld=0 z=0", ifc1.out_valid, zcount1);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_two_beat();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_no_compress();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
